// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: decodes the offered instruction combinationally and queues the
// decoded record in a small FIFO with valid/ready on both sides.
module rv32_decode_stage #(
  parameter int DEPTH        = 2,
  parameter bit ENABLE_M     = 1'b0,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_imm,
  output logic        out_illegal,
  output logic [15:0] illegal_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]    DEPTH_C = 3'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  // Register fields are plain slices of the instruction, so only inst/imm/illegal are stored.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        illegal;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          dec_rec;
  rec_t          rd_rec;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    count;
  logic [31:0]   dec_imm;
  logic          dec_illegal;
  logic          push;
  logic          pop;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != 3'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Immediate selection by format; sign always comes from inst[31].
  always_comb begin
    dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
    case (opcode)
      7'h23:        dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      7'h37, 7'h17: dec_imm = {in_inst[31:12], 12'h000};
      7'h6F:        dec_imm = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      7'h63:        dec_imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      default:      dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
    endcase
  end

  // Legality check; opcodes with inst[1:0] != 2'b11 fall into the default arm.
  always_comb begin
    dec_illegal = 1'b0;
    case (opcode)
      7'h03: dec_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      7'h23: dec_illegal = (funct3 > 3'd2);
      7'h63: dec_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      7'h67: dec_illegal = (funct3 != 3'd0);
      7'h13: begin
        if (funct3 == 3'd1)      dec_illegal = (funct7 != 7'h00);
        else if (funct3 == 3'd5) dec_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        else                     dec_illegal = 1'b0;
      end
      7'h33: begin
        if (funct7 == 7'h00)      dec_illegal = 1'b0;
        else if (funct7 == 7'h20) dec_illegal = (funct3 != 3'd0) && (funct3 != 3'd5);
        else if (funct7 == 7'h01) dec_illegal = !ENABLE_M;
        else                      dec_illegal = 1'b1;
      end
      7'h73: begin
        if (funct3 == 3'd4)       dec_illegal = 1'b1;
        else if (funct3 != 3'd0)  dec_illegal = !ENABLE_ZICSR;
        else                      dec_illegal = (in_inst[31:7] != 25'h0) && (in_inst[31:7] != 25'h2000);
      end
      7'h37, 7'h17, 7'h6F, 7'h0F: dec_illegal = 1'b0;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_rec = '{pc: in_pc, inst: in_inst, imm: dec_imm, illegal: dec_illegal};
  assign rd_rec  = mem[rd_ptr];

  assign out_pc      = rd_rec.pc;
  assign out_opcode  = rd_rec.inst[6:0];
  assign out_rd      = rd_rec.inst[11:7];
  assign out_rs1     = rd_rec.inst[19:15];
  assign out_rs2     = rd_rec.inst[24:20];
  assign out_funct3  = rd_rec.inst[14:12];
  assign out_funct7  = rd_rec.inst[31:25];
  assign out_imm     = rd_rec.imm;
  assign out_illegal = rd_rec.illegal;

  // FIFO storage, pointers, occupancy and the saturating illegal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= 3'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      illegal_count <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_rec;
        wr_ptr      <= ptr_inc(wr_ptr);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push && dec_illegal && (illegal_count != 16'hFFFF)) begin
        illegal_count <= illegal_count + 16'd1;
      end else begin
        illegal_count <= illegal_count;
      end
    end
  end

endmodule

// File: doc/rv32_decode_stage.md
RV32_DECODE_STAGE -- requirements
Module: rv32_decode_stage

Interface
REQ-001 The block SHALL have one clock `clk`; reset `rst` is synchronous and active-high.
REQ-002 The block SHALL have these parameters:
- DEPTH, 2, output buffer entries; legal range 1..4.
- ENABLE_M, 0, accept RV32M OP encodings.
- ENABLE_ZICSR, 1, accept CSR funct3 values on SYSTEM.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  buffer can accept
- in_pc  in  32  instruction address
- in_inst  in  32  raw instruction
- out_valid  out  1  decoded entry available
- out_ready  in  1  consumer accepts
- out_pc  out  32  passed-through address
- out_opcode  out  7  inst[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20]
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  entry is an illegal encoding
- illegal_count  out  16  saturating count of illegal entries accepted

Function
REQ-004 The block SHALL decode combinationally at the input and store the decoded record in a DEPTH-entry FIFO, giving 1-cycle latency from input handshake to out_valid.
REQ-005 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-006 in_ready SHALL equal (count < DEPTH); out_valid SHALL equal (count != 0), where count is the registered occupancy.
REQ-007 When full, a push SHALL NOT occur, even if a pop happens the same cycle.
REQ-008 A simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-009 Out_* fields SHALL be held stable while out_valid && !out_ready.
REQ-010 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-011 out_imm SHALL be selected by opcode, with the sign bit always inst[31]:
- STORE (0x23): S-type {inst[31:25], inst[11:7]}.
- LUI/AUIPC (0x37/0x17): {inst[31:12], 12'b0}.
- JAL (0x6F): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- BRANCH (0x63): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- All others: I-type inst[31:20].
REQ-012 out_illegal SHALL be 1 when any of the following holds:
- inst[1:0] != 2'b11.
- Opcode is not one of 0x33, 0x13, 0x03, 0x23, 0x37, 0x17, 0x6F, 0x67, 0x63, 0x73, 0x0F.
- LOAD with funct3 in {3, 6, 7}.
- STORE with funct3 > 2.
- BRANCH with funct3 in {2, 3}.
- JALR with funct3 != 0.
- IMM: SLLI with funct7 != 0x00, or SRLI/SRAI with funct7 not in {0x00, 0x20}.
- OP: funct7 = 0x20 with funct3 not in {0, 5}.
- OP: funct7 = 0x01 while ENABLE_M = 0.
- OP: any other funct7 value.
- SYSTEM with funct3 = 4.
- SYSTEM with funct3 != 0 while ENABLE_ZICSR = 0.
- SYSTEM with funct3 = 0 and inst[31:7] not in {0, 0x2000} (ECALL/EBREAK).
REQ-013 The fields rd/rs1/rs2/funct3/funct7/imm SHALL be produced for illegal entries as for legal ones; the consumer gates on out_illegal.
REQ-014 illegal_count SHALL increment by 1 on each input transfer whose decode is illegal, and saturate at 0xFFFF.

Reset
REQ-015 On rst=1 at a clk edge, the block SHALL clear count, pointers and illegal_count, so that out_valid=0, in_ready=1 and illegal_count=0 on the next cycle.
REQ-016 Reset asserted mid-stream SHALL discard all buffered entries; no entry accepted before reset SHALL appear after reset.
REQ-017 After reset, data outputs SHALL read 0 until the first push.

Verification
REQ-018 ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
REQ-019 JAL x1,-4 (0xFFDFF0EF) -> imm=0xFFFFFFFC; BEQ x0,x0,-8 (0xFE000CE3) -> imm=0xFFFFFFF8; both illegal=0.
REQ-020 MUL x1,x2,x3 (0x023100B3): with ENABLE_M=0 -> illegal=1 and illegal_count=1; with ENABLE_M=1 -> illegal=0.
REQ-021 DEPTH=2, out_ready=0, 3 back-to-back inputs -> in_ready=0 after the 2nd, 3rd held off; raising out_ready with in_valid held -> pop-only cycle, then the 3rd is accepted; output order 1, 2, 3.
REQ-022 Reset with 2 entries buffered -> out_valid=0, in_ready=1 and illegal_count=0 on the following cycle; the stale entries never appear.
REQ-023 Force illegal_count to 0xFFFF via 65535 illegal inputs (0x00000000), then send one more -> count stays 0xFFFF.
